// File: rtl/bcd_pkg.sv
// Shared BCD/binary constants and state type used by the BCD-to-binary converter
// and the binary-to-BCD display path.
package bcd_pkg;

  localparam int BCD_DIGITS = 6;
  localparam int BIN_W      = 20;
  localparam int BCD_W      = 24;
  localparam int IDX_W      = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BCD_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  // True when any packed nibble lies outside 0..9.
  function automatic logic has_invalid_digit(input logic [BCD_W-1:0] value);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (value[i*4 +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
interface bcd2bin_seq_if;
  import bcd_pkg::*;

  logic             START;
  logic [BCD_W-1:0] BCD_IN;
  logic             BUSY;
  logic             DONE;
  logic [BIN_W-1:0] BIN_OUT;
  logic             ERR;

  modport master (
    output START,
    output BCD_IN,
    input  BUSY,
    input  DONE,
    input  BIN_OUT,
    input  ERR
  );

  modport slave (
    input  START,
    input  BCD_IN,
    output BUSY,
    output DONE,
    output BIN_OUT,
    output ERR
  );

endinterface

// File: rtl/mul10_add.sv
// One Horner step of the conversion: result = acc*10 + digit, truncated to BIN_W.
module mul10_add
  import bcd_pkg::*;
(
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] result
);

  // Shift-and-add keeps the x10 free of a real multiplier.
  assign result = (acc << 3) + (acc << 1) + {{(BIN_W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential six-digit BCD to binary converter, one digit per clock, MSD first.
// Optional range checking of the latched nibbles is enabled by BCD2BIN_RANGE_CHECK_EN.
module bcd2bin_seq
  import bcd_pkg::*;
(
  input logic          CLK,
  input logic          RST,
  bcd2bin_seq_if.slave bus
);

  state_t           state;
  logic [BCD_W-1:0] operand;
  logic [BIN_W-1:0] acc;
  logic [IDX_W-1:0] index;
  logic [3:0]       digit;
  logic [BIN_W-1:0] next_acc;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin_out;
  logic             range_err;

  assign digit = operand[{index, 2'b00} +: 4];

  mul10_add u_mul10_add (
    .acc    (acc),
    .digit  (digit),
    .result (next_acc)
  );

`ifdef BCD2BIN_RANGE_CHECK_EN
  logic err;
  assign range_err = has_invalid_digit(operand);
  assign bus.ERR   = err;
`else
  assign range_err = 1'b0;
  assign bus.ERR   = 1'b0;
`endif

  // Reset wins over everything, so an interrupted conversion never reaches DONE.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      operand <= '0;
      acc     <= '0;
      index   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
`ifdef BCD2BIN_RANGE_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (bus.START) begin
            operand <= bus.BCD_IN;
            acc     <= '0;
            index   <= LAST_IDX;
            busy    <= 1'b1;
            state   <= CONV;
          end else begin
            state   <= IDLE;
          end
        end
        CONV: begin
          acc <= next_acc;
          if (index == '0) begin
            bin_out <= range_err ? '0 : next_acc;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FIN;
`ifdef BCD2BIN_RANGE_CHECK_EN
            err     <= range_err;
`endif
          end else begin
            index <= index - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.BIN_OUT = bin_out;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: directed vectors push expected results,
// a negedge monitor pops and compares whenever DONE is seen.
module tb_bcd2bin_seq;
  import bcd_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [BIN_W:0] expq[$];

  bcd2bin_seq_if bus ();

  bcd2bin_seq dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drives a one-edge START pulse; returns at the negedge after the sampling edge.
  task automatic applyStimulus(input logic [BCD_W-1:0] bcd, input logic [BIN_W-1:0] exp_bin,
                               input logic exp_err);
    @(negedge clk);
    bus.START  = 1'b1;
    bus.BCD_IN = bcd;
    expq.push_back({exp_bin, exp_err});
    @(posedge clk);
    @(negedge clk);
    bus.START  = 1'b0;
    bus.BCD_IN = ~bcd;
  endtask

  // Starting at sample k0 (negedge after edge k0), waits for DONE, checks its
  // sample index and how many samples BUSY was high before it.
  task automatic waitDone(input int k0, input int exp_k, input int exp_busy, input string name);
    int k;
    int busy_cnt;
    bit seen;
    k        = k0;
    seen     = 1'b0;
    busy_cnt = bus.BUSY ? 1 : 0;
    while (!seen && k < k0 + 20) begin
      @(negedge clk);
      k++;
      if (bus.DONE) seen = 1'b1;
      else if (bus.BUSY) busy_cnt++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done expected=done", name);
    end else begin
      checkOutput({name, "_latency"}, k, exp_k);
      checkOutput({name, "_busy_cycles"}, busy_cnt, exp_busy);
      checkOutput({name, "_busy_at_done"}, {31'b0, bus.BUSY}, 0);
    end
  endtask

  always @(negedge clk) begin
    logic [BIN_W:0] e;
    if (rst && bus.DONE) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=done expected=none bin=%0d", bus.BIN_OUT);
      end else begin
        e = expq.pop_front();
        checkOutput("bin_out", {12'b0, bus.BIN_OUT}, {12'b0, e[BIN_W:1]});
        checkOutput("err", {31'b0, bus.ERR}, {31'b0, e[0]});
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    bus.START  = 1'b0;
    bus.BCD_IN = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, bus.BUSY}, 0);
    checkOutput("reset_done", {31'b0, bus.DONE}, 0);
    checkOutput("reset_bin", {12'b0, bus.BIN_OUT}, 0);
    checkOutput("reset_err", {31'b0, bus.ERR}, 0);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(24'h000000, 20'd0, 1'b0);
    waitDone(0, 6, 6, "zero");
    applyStimulus(24'h999999, 20'hF423F, 1'b0);
    waitDone(0, 6, 6, "max");
    applyStimulus(24'h524287, 20'h7FFFF, 1'b0);
    waitDone(0, 6, 6, "v524287");
    applyStimulus(24'h123456, 20'h1E240, 1'b0);
    waitDone(0, 6, 6, "v123456");

    // START re-pulse at edge 3 must be ignored while busy.
    applyStimulus(24'h000042, 20'd42, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.START  = 1'b1;
    bus.BCD_IN = 24'h000001;
    @(negedge clk);
    bus.START  = 1'b0;
    waitDone(3, 6, 3, "repulse");
    repeat (10) @(negedge clk);

    // Reset sampled at edge 4 aborts; the next edge accepts a new START.
    applyStimulus(24'h000123, 20'd123, 1'b0);
    void'(expq.pop_back());
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {31'b0, bus.BUSY}, 0);
    checkOutput("abort_done", {31'b0, bus.DONE}, 0);
    checkOutput("abort_bin", {12'b0, bus.BIN_OUT}, 0);
    checkOutput("abort_err", {31'b0, bus.ERR}, 0);
    rst        = 1'b1;
    bus.START  = 1'b1;
    bus.BCD_IN = 24'h000007;
    expq.push_back({20'd7, 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.START  = 1'b0;
    waitDone(0, 6, 6, "after_reset");

    // START held high: conversions every 7 cycles.
    @(negedge clk);
    bus.START  = 1'b1;
    bus.BCD_IN = 24'h000010;
    expq.push_back({20'd10, 1'b0});
    expq.push_back({20'd20, 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.BCD_IN = 24'h000020;
    waitDone(0, 6, 6, "b2b_first");
    @(negedge clk);
    bus.START  = 1'b0;
    waitDone(7, 13, 6, "b2b_second");

`ifdef BCD2BIN_RANGE_CHECK_EN
    applyStimulus(24'h12A456, 20'd0, 1'b1);
`else
    applyStimulus(24'h12A456, 20'd130456, 1'b0);
`endif
    waitDone(0, 6, 6, "bad_nibble");

    repeat (10) @(negedge clk);
    checkOutput("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 SHALL have no parameters; digit count and widths are fixed by shared-package constants.
REQ-002 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset: synchronous, active-low.
REQ-004 SHALL have port START  input  1  request conversion of BCD_IN; sampled only when not busy.
REQ-005 SHALL have port BCD_IN  input  24  six packed BCD digits; [23:20] most significant, [3:0] least significant.
REQ-006 SHALL have port BUSY  output  1  conversion in progress.
REQ-007 SHALL have port DONE  output  1  one-cycle pulse; result valid.
REQ-008 SHALL have port BIN_OUT  output  20  unsigned binary result, range 0..999999.
REQ-009 SHALL have port ERR  output  1  invalid BCD digit detected in the last conversion.

Function
REQ-010 SHALL implement states IDLE, CONV, FIN.
- IDLE/FIN with START=1 -> CONV.
- CONV after last digit -> FIN.
- FIN with START=0 -> IDLE.
REQ-011 SHALL, on the edge that samples START=1 in IDLE or FIN, do all of the following:
- latch BCD_IN into an internal register;
- clear the accumulator;
- set the digit index to 5;
- set BUSY=1.
REQ-012 SHALL, on each CONV edge, compute acc <= acc*10 + digit[index] and then decrement the index.
- acc*10 is formed as (acc<<3)+(acc<<1).
- The arithmetic is 20 bits wide and cannot overflow for valid input.
REQ-013 SHALL, on the edge that processes digit 0, do all of the following:
- load BIN_OUT;
- assert DONE;
- deassert BUSY;
- enter FIN.
REQ-014 SHALL produce DONE exactly 6 edges after the START-sampling edge, for exactly one cycle, unless a new START is accepted in FIN.
- In that case DONE still drops after one cycle.
REQ-015 SHALL hold BIN_OUT and ERR stable from DONE until the edge where the next conversion completes.
REQ-016 SHALL ignore START while BUSY=1; the latched operand and progress are unaffected.
REQ-017 SHALL accept back-to-back conversions: START held high gives one conversion every 7 cycles.
REQ-018 SHALL ignore changes on BCD_IN after the START-sampling edge.

Reset
REQ-019 SHALL, on an edge with RST=0, do all of the following:
- force state IDLE;
- set BUSY=0, DONE=0, BIN_OUT=0, ERR=0;
- clear the accumulator, index and latched operand.
REQ-020 SHALL give RST priority over START and over any in-progress conversion; an aborted conversion produces no DONE.
REQ-021 SHALL, on the first edge with RST=1 and START=1, accept a new conversion.

Configuration
REQ-022 SHALL recognise the macro BCD2BIN_RANGE_CHECK_EN.
REQ-023 SHALL, with BCD2BIN_RANGE_CHECK_EN defined, set ERR=1 together with DONE if any latched nibble exceeds 9.
- BIN_OUT is then forced to 0.
- Latency is unchanged.
REQ-024 SHALL, without BCD2BIN_RANGE_CHECK_EN:
- tie ERR to 0;
- process nibbles as-is, with the result truncated to 20 bits.

Structure
REQ-025 SHALL take the following from shared package bcd_pkg, shared with the binary-to-BCD display path:
- BCD_DIGITS=6;
- BIN_W=20;
- BCD_W=24;
- the state typedef (IDLE, CONV, FIN).
REQ-026 SHALL place the multiply-by-10-add step in one combinational sub-module, mul10_add.
- Inputs: 20-bit acc, 4-bit digit.
- Output: 20-bit result.
REQ-027 SHALL contain no other sub-modules.

Verification
REQ-028 SHALL cover: BCD_IN=0x000000, START pulse -> DONE after 6 edges, BIN_OUT=0, ERR=0, BUSY high for 6 cycles.
REQ-029 SHALL cover: BCD_IN=0x999999 -> BIN_OUT=0xF423F (999999); then 0x524287 -> BIN_OUT=0x7FFFF; then 0x123456 -> BIN_OUT=0x1E240.
REQ-030 SHALL cover: START re-pulsed with BCD_IN=0x000001 at edge 3 of a 0x000042 conversion -> BIN_OUT=42, no second DONE.
REQ-031 SHALL cover: RST=0 at edge 4 of a conversion -> no DONE, all outputs 0; START next cycle with 0x000007 -> BIN_OUT=7.
REQ-032 SHALL cover: START held high with 0x000010 then 0x000020 -> DONE pulses 7 cycles apart, BIN_OUT=10 then 20.
REQ-033 SHALL cover: with BCD2BIN_RANGE_CHECK_EN, BCD_IN=0x12A456 -> ERR=1, BIN_OUT=0; without the macro -> ERR=0.
